// File: rtl/inc_arb_pkg.sv
// Shared types and constants for the two-requester incrementer arbiter.
package inc_arb_pkg;
  typedef enum logic {IDLE, HOLD} inc_arb_state_t;
  localparam int N_REQ = 2;
  localparam logic [15:0] WORD_MAX = 16'hFFFF;
endpackage

// File: rtl/inc_16.sv
// Fixed 16-bit incrementer shared by the datapath address sources.
module inc_16 (
  input  logic [15:0] a,
  output logic [15:0] y
);
  assign y = a + 16'd1;
endmodule

// File: rtl/inc_arb_grant.sv
// Combinational one-hot grant for the shared incrementer slot.
// INC_ARB_ROUND_ROBIN_EN selects round-robin; otherwise requester 0 has fixed priority.
module inc_arb_grant
  import inc_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid,
  input  logic             slot_free,
`ifdef INC_ARB_ROUND_ROBIN_EN
  input  logic             last_grant,
`endif
  output logic [N_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (slot_free) begin
      if (req_valid == 2'b11) begin
`ifdef INC_ARB_ROUND_ROBIN_EN
        // The requester that did not win last time goes first.
        grant = last_grant ? 2'b01 : 2'b10;
`else
        grant = 2'b01;
`endif
      end else if (req_valid[0]) begin
        grant = 2'b01;
      end else if (req_valid[1]) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/inc_16_arbiter.sv
// Shares one inc_16 between two requesters with a single registered result slot.
// Define INC_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority to requester 0).
module inc_16_arbiter
  import inc_arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [WIDTH-1:0]     req_data0,
  input  logic [WIDTH-1:0]     req_data1,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_wrap,
  input  logic [N_REQ-1:0]     rsp_ready,
  output inc_arb_state_t       state_dbg
);

  // Handshakes: a request transfers when req_valid[i] & req_ready[i] at a rising
  // edge; a response is consumed when rsp_valid[i] & rsp_ready[i]. The slot can
  // be released and refilled in the same cycle.

  inc_arb_state_t   state, state_nxt;
  logic             owner, owner_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             wrap_nxt;
  logic             slot_free;
  logic             handshake;
  logic [N_REQ-1:0] grant;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] inc_out;

  // Reset gates the slot so nothing is accepted during the reset cycle.
  assign slot_free = ~reset & ((state == IDLE) | rsp_ready[owner]);

`ifdef INC_ARB_ROUND_ROBIN_EN
  logic last_grant, last_grant_nxt;

  inc_arb_grant u_grant (
    .req_valid  (req_valid),
    .slot_free  (slot_free),
    .last_grant (last_grant),
    .grant      (grant)
  );
`else
  inc_arb_grant u_grant (
    .req_valid  (req_valid),
    .slot_free  (slot_free),
    .grant      (grant)
  );
`endif

  assign operand   = grant[1] ? req_data1 : req_data0;
  assign handshake = |grant;
  assign req_ready = grant;

  inc_16 u_inc (
    .a (operand),
    .y (inc_out)
  );

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    data_nxt  = rsp_data;
    wrap_nxt  = rsp_wrap;
`ifdef INC_ARB_ROUND_ROBIN_EN
    last_grant_nxt = last_grant;
`endif
    case (state)
      IDLE: if (handshake) state_nxt = HOLD;
      HOLD: if (rsp_ready[owner] && !handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (handshake) begin
      owner_nxt = grant[1];
      data_nxt  = inc_out;
      wrap_nxt  = (operand == WORD_MAX);
`ifdef INC_ARB_ROUND_ROBIN_EN
      last_grant_nxt = grant[1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rsp_data <= '0;
      rsp_wrap <= 1'b0;
`ifdef INC_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rsp_data <= data_nxt;
      rsp_wrap <= wrap_nxt;
`ifdef INC_ARB_ROUND_ROBIN_EN
      last_grant <= last_grant_nxt;
`endif
    end
  end

  assign rsp_valid = (state == HOLD) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign state_dbg = state;

endmodule

// File: tb/tb_inc_16_arbiter.sv
// Bench for inc_16_arbiter: directed vector table plus randomized traffic against a reference model.
module tb_inc_16_arbiter;
  import inc_arb_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [15:0]    req_data0;
  logic [15:0]    req_data1;
  logic [1:0]     req_ready;
  logic [1:0]     rsp_valid;
  logic [15:0]    rsp_data;
  logic           rsp_wrap;
  logic [1:0]     rsp_ready;
  inc_arb_state_t state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  inc_16_arbiter #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_wrap  (rsp_wrap),
    .rsp_ready (rsp_ready),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: one result slot described by who holds it and its value.
  bit        m_held;
  int        m_own;
  int        m_last;
  bit [15:0] m_val;
  bit        m_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_own = 0; m_last = 1; m_val = 16'h0000; m_wrap = 0;
  endtask

  // Applies one cycle of inputs; returns the observed req_ready before the edge
  // and the registered outputs after it, checking both against the model.
  task automatic step(input logic rst, input logic [1:0] rv, input logic [15:0] d0,
                      input logic [15:0] d1, input logic [1:0] rr,
                      output logic [1:0] o_rdy, output logic [1:0] o_vld,
                      output logic [15:0] o_data, output logic o_wrap);
    bit        free;
    int        win;
    bit [1:0]  e_rdy;
    bit [16:0] sum;
    bit [15:0] opnd;
    reset = rst; req_valid = rv; req_data0 = d0; req_data1 = d1; rsp_ready = rr;
    #1;
    free  = !m_held || rr[m_own];
    e_rdy = 2'b00;
    win   = 0;
    if (!rst && free && rv != 2'b00) begin
      if (rv == 2'b11) begin
`ifdef INC_ARB_ROUND_ROBIN_EN
        win = 1 - m_last;
`else
        win = 0;
`endif
      end else begin
        win = rv[0] ? 0 : 1;
      end
      e_rdy = 2'b01 << win;
    end
    o_rdy = req_ready;
    chk("model_req_ready", {30'b0, o_rdy}, {30'b0, e_rdy});
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (e_rdy != 2'b00) begin
      opnd   = (win == 1) ? d1 : d0;
      sum    = {1'b0, opnd} + 17'd1;
      m_held = 1; m_own = win; m_last = win;
      m_val  = sum[15:0];
      m_wrap = sum[16];
    end else if (m_held && rr[m_own]) begin
      m_held = 0;
    end
    #1;
    o_vld = rsp_valid; o_data = rsp_data; o_wrap = rsp_wrap;
    chk("model_rsp_valid", {30'b0, o_vld}, m_held ? (32'd1 << m_own) : 32'd0);
    chk("model_rsp_data", {16'b0, o_data}, {16'b0, m_val});
    chk("model_rsp_wrap", {31'b0, o_wrap}, {31'b0, m_wrap});
    chk("model_state", {31'b0, state_dbg == HOLD}, {31'b0, m_held});
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  rr;
    logic [1:0]  e_rdy;
    logic [1:0]  e_vld;
    logic [15:0] e_data;
    logic        e_wrap;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [1:0] rv, input logic [15:0] d0,
                     input logic [15:0] d1, input logic [1:0] rr, input logic [1:0] e_rdy,
                     input logic [1:0] e_vld, input logic [15:0] e_data, input logic e_wrap);
    vec_t v;
    v.rst = rst; v.rv = rv; v.d0 = d0; v.d1 = d1; v.rr = rr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_wrap = e_wrap;
    vq.push_back(v);
  endtask

  initial begin
    logic [1:0]  o_rdy, o_vld;
    logic [15:0] o_data;
    logic        o_wrap;
    logic [15:0] d0, d1;

    reset = 1'b1; req_valid = 2'b00; req_data0 = '0; req_data1 = '0; rsp_ready = 2'b00;
    model_reset();

    // rst, req_valid, d0, d1, rsp_ready | req_ready, rsp_valid, rsp_data, rsp_wrap
    add(1, 2'b11, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 0);
    add(1, 2'b11, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 0);
    add(0, 2'b01, 16'h0005, 16'h0000, 2'b01, 2'b01, 2'b01, 16'h0006, 0);
    add(0, 2'b10, 16'h0000, 16'hFFFF, 2'b01, 2'b10, 2'b10, 16'h0000, 1);
    add(0, 2'b10, 16'h0000, 16'hFFFB, 2'b10, 2'b10, 2'b10, 16'hFFFC, 0);
    for (int i = 0; i < 3; i++)
      add(0, 2'b11, 16'h0020, 16'h0030, 2'b00, 2'b00, 2'b10, 16'hFFFC, 0);
    add(0, 2'b11, 16'h0020, 16'h0030, 2'b10, 2'b01, 2'b01, 16'h0021, 0);
`ifdef INC_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) add(0, 2'b11, 16'h0000, 16'h0010, 2'b11, 2'b10, 2'b10, 16'h0011, 0);
      else            add(0, 2'b11, 16'h0000, 16'h0010, 2'b11, 2'b01, 2'b01, 16'h0001, 0);
    end
`else
    for (int i = 0; i < 4; i++)
      add(0, 2'b11, 16'h0000, 16'h0010, 2'b11, 2'b01, 2'b01, 16'h0001, 0);
`endif
    add(0, 2'b00, 16'h0000, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h0001, 0);
    add(0, 2'b10, 16'h0000, 16'h0007, 2'b00, 2'b10, 2'b10, 16'h0008, 0);
    add(1, 2'b11, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 0);
    add(0, 2'b11, 16'h0040, 16'h0050, 2'b00, 2'b01, 2'b01, 16'h0041, 0);
    add(0, 2'b01, 16'h0041, 16'h0000, 2'b01, 2'b01, 2'b01, 16'h0042, 0);
    add(0, 2'b10, 16'h0000, 16'h0001, 2'b10, 2'b00, 2'b01, 16'h0042, 0);
    add(0, 2'b00, 16'h0000, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0042, 0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].rv, vq[i].d0, vq[i].d1, vq[i].rr, o_rdy, o_vld, o_data, o_wrap);
      chk($sformatf("vec%0d_req_ready", i), {30'b0, o_rdy}, {30'b0, vq[i].e_rdy});
      chk($sformatf("vec%0d_rsp_valid", i), {30'b0, o_vld}, {30'b0, vq[i].e_vld});
      chk($sformatf("vec%0d_rsp_data", i), {16'b0, o_data}, {16'b0, vq[i].e_data});
      chk($sformatf("vec%0d_rsp_wrap", i), {31'b0, o_wrap}, {31'b0, vq[i].e_wrap});
    end

    // Randomized traffic, checked inside step against the model.
    for (int i = 0; i < 400; i++) begin
      d0 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      d1 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step(($urandom_range(0, 39) == 0), 2'($urandom), d0, d1, 2'($urandom),
           o_rdy, o_vld, o_data, o_wrap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
